// File: rtl/md_unit.sv
// md_unit: multiply/divide unit owning the HI/LO registers.
// {loen,hien}=01 -> mthi, 10 -> mtlo, 11 -> mult/multu/div/divu chosen by funct.
// Multi-cycle operations run from operands captured at acceptance and hold
// busy until HI/LO are written; requests arriving while busy are dropped.
module md_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        hien,
  input  logic        loen,
  input  logic [5:0]  funct,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  output logic        start,
  output logic        busy,
  output logic        stall,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int CNT_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2
  } state_t;

  // funct codes 24..27 (mult, multu, div, divu) share the prefix 6'b0110xx
  function automatic logic is_md_funct(input logic [5:0] f);
    return (f[5:2] == 4'b0110);
  endfunction

  // two's-complement negate when requested
  function automatic logic [31:0] cond_neg(input logic [31:0] v, input logic neg);
    return neg ? (32'd0 - v) : v;
  endfunction

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   a_q, a_d;
  logic [31:0]   b_q, b_d;
  logic          sgn_q, sgn_d;
  logic          busy_q, busy_d;
  logic [31:0]   hi_q, hi_d;
  logic [31:0]   lo_q, lo_d;

  logic [1:0]    req_s;
  logic          start_s;
  logic          mthi_s;
  logic          mtlo_s;

  logic [63:0]   mul_a_s;
  logic [63:0]   mul_b_s;
  logic [63:0]   prod_s;

  logic          neg_a_s;
  logic          neg_b_s;
  logic [31:0]   abs_a_s;
  logic [31:0]   abs_b_s;
  logic          div_zero_s;
  logic [31:0]   den_s;
  logic [31:0]   uquot_s;
  logic [31:0]   urem_s;
  logic [31:0]   quot_s;
  logic [31:0]   rem_s;

  // request decode; nothing is accepted while an operation is in flight
  assign req_s   = {loen, hien};
  assign start_s = (req_s == 2'b11) && is_md_funct(funct) && !busy_q;
  assign mthi_s  = (req_s == 2'b01) && !busy_q;
  assign mtlo_s  = (req_s == 2'b10) && !busy_q;

  assign start = start_s;
  assign busy  = busy_q;
  assign stall = start_s | busy_q;
  assign hi    = hi_q;
  assign lo    = lo_q;

  // product: extend operands to 64 bits (sign or zero); low 64 bits of the
  // product are correct for both signednesses
  assign mul_a_s = {{32{sgn_q & a_q[31]}}, a_q};
  assign mul_b_s = {{32{sgn_q & b_q[31]}}, b_q};
  assign prod_s  = mul_a_s * mul_b_s;

  // quotient/remainder: divide magnitudes, then restore signs. Quotient
  // truncates toward zero; remainder takes the dividend's sign. The
  // 0x80000000 / -1 case falls out naturally as 0x80000000 rem 0.
  assign neg_a_s    = sgn_q & a_q[31];
  assign neg_b_s    = sgn_q & b_q[31];
  assign abs_a_s    = cond_neg(a_q, neg_a_s);
  assign abs_b_s    = cond_neg(b_q, neg_b_s);
  assign div_zero_s = (b_q == 32'd0);
  assign den_s      = div_zero_s ? 32'd1 : abs_b_s;
  assign uquot_s    = abs_a_s / den_s;
  assign urem_s     = abs_a_s % den_s;
  assign quot_s     = cond_neg(uquot_s, neg_a_s ^ neg_b_s);
  assign rem_s      = cond_neg(urem_s, neg_a_s);

  // next-state: accept ops/moves in IDLE, count down, write HI/LO on last busy cycle
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    sgn_d   = sgn_q;
    busy_d  = busy_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      S_IDLE: begin
        if (start_s) begin
          state_d = funct[1] ? S_DIV : S_MUL;
          cnt_d   = funct[1] ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
          a_d     = rs_data;
          b_d     = rt_data;
          sgn_d   = ~funct[0];
          busy_d  = 1'b1;
        end else if (mthi_s) begin
          hi_d = rs_data;
        end else if (mtlo_s) begin
          lo_d = rs_data;
        end else begin
          hi_d = hi_q;
        end
      end
      S_MUL: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          hi_d    = prod_s[63:32];
          lo_d    = prod_s[31:0];
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end else begin
          busy_d = 1'b1;
        end
      end
      S_DIV: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          // divide by zero still spends the full latency but leaves HI/LO alone
          if (!div_zero_s) begin
            hi_d = rem_s;
            lo_d = quot_s;
          end else begin
            hi_d = hi_q;
          end
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end else begin
          busy_d = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // state registers with synchronous reset that overrides any request
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      sgn_q   <= 1'b0;
      busy_q  <= 1'b0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sgn_q   <= sgn_d;
      busy_q  <= busy_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit: directed vectors for md_unit. Stimulus pushes expected {hi,lo}
// for every multi-cycle op into a queue; a monitor pops and compares each
// time busy falls. Timing and hold behaviour are checked inline.
module tb_md_unit;

  logic        clk;
  logic        reset;
  logic        hien;
  logic        loen;
  logic [5:0]  funct;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        start;
  logic        busy;
  logic        stall;
  logic [31:0] hi;
  logic [31:0] lo;

  int          n_total = 0;
  int          n_bad   = 0;
  logic [63:0] exp_q[$];
  logic [63:0] mon_e;
  logic        busy_prev = 1'b0;

  md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk     (clk),
    .reset   (reset),
    .hien    (hien),
    .loen    (loen),
    .funct   (funct),
    .rs_data (rs_data),
    .rt_data (rt_data),
    .start   (start),
    .busy    (busy),
    .stall   (stall),
    .hi      (hi),
    .lo      (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // monitor: each busy falling edge presents a result (or reset abort)
  always @(negedge clk) begin
    if (busy_prev === 1'b1 && busy === 1'b0) begin
      if (exp_q.size() == 0) begin
        n_total++;
        n_bad++;
        $display("FAIL sb_underflow: got result 0x%08h_%08h expected none", hi, lo);
      end else begin
        mon_e = exp_q.pop_front();
        check("sb_hi", hi, mon_e[63:32]);
        check("sb_lo", lo, mon_e[31:0]);
      end
    end
    busy_prev <= busy;
  end

  // mode 0: plain; 1: change rs/rt mid-op; 2: assert mthi 0xAAAA while busy
  task automatic do_op(input string name, input logic [5:0] f, input logic [31:0] a,
                       input logic [31:0] b, input logic [63:0] exp, input int n, input int mode);
    int          cnt;
    int          bad_ctl;
    int          bad_hold;
    logic [31:0] hi0;
    logic [31:0] lo0;
    hien = 1'b1; loen = 1'b1; funct = f; rs_data = a; rt_data = b;
    #1;
    check({name, "_start"}, {31'd0, start}, 32'd1);
    check({name, "_stall0"}, {31'd0, stall}, 32'd1);
    exp_q.push_back(exp);
    hi0 = hi;
    lo0 = lo;
    cycle();
    hien = 1'b0; loen = 1'b0; funct = 6'd0;
    cnt = 0; bad_ctl = 0; bad_hold = 0;
    while (busy === 1'b1 && cnt < 100) begin
      cnt++;
      if (stall !== 1'b1 || start !== 1'b0) bad_ctl++;
      if (hi !== hi0 || lo !== lo0) bad_hold++;
      if (mode == 1 && cnt == 2) begin
        rs_data = 32'h12345678;
        rt_data = 32'h9ABCDEF0;
      end
      if (mode == 2 && cnt == 2) begin
        hien = 1'b1;
        rs_data = 32'h0000AAAA;
      end else begin
        hien = 1'b0;
      end
      cycle();
    end
    hien = 1'b0;
    check({name, "_busy_cycles"}, 32'(cnt), 32'(n));
    check({name, "_ctl_while_busy"}, 32'(bad_ctl), 32'd0);
    check({name, "_hold_while_busy"}, 32'(bad_hold), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; hien = 1'b0; loen = 1'b0; funct = 6'd0;
    rs_data = 32'd0; rt_data = 32'd0;
    cycle();
    cycle();
    reset = 1'b0;
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_stall", {31'd0, stall}, 32'd0);

    // -3 * 5 = -15
    do_op("mult", 6'd24, 32'hFFFFFFFD, 32'd5, 64'hFFFFFFFF_FFFFFFF1, 5, 0);
    // 0xFFFFFFFF * 2 unsigned, operands changed mid-op
    do_op("multu", 6'd25, 32'hFFFFFFFF, 32'd2, 64'h00000001_FFFFFFFE, 5, 1);
    // -7 / 2 -> q=-3, r=-1
    do_op("div", 6'd26, 32'hFFFFFFF9, 32'd2, 64'hFFFFFFFF_FFFFFFFD, 10, 0);
    do_op("divu", 6'd27, 32'd7, 32'd2, 64'h00000001_00000003, 10, 0);
    // overflow case
    do_op("div_ovf", 6'd26, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, 10, 0);

    // mthi / mtlo
    hien = 1'b1; loen = 1'b0; rs_data = 32'h00001234;
    #1;
    check("mthi_start", {31'd0, start}, 32'd0);
    check("mthi_stall", {31'd0, stall}, 32'd0);
    cycle();
    hien = 1'b0; loen = 1'b1; rs_data = 32'h00005678;
    check("mthi_hi", hi, 32'h00001234);
    check("mthi_lo", lo, 32'h80000000);
    check("mthi_busy", {31'd0, busy}, 32'd0);
    cycle();
    loen = 1'b0;
    check("mtlo_hi", hi, 32'h00001234);
    check("mtlo_lo", lo, 32'h00005678);

    // divu by zero leaves HI/LO untouched
    do_op("divu_zero", 6'd27, 32'd100, 32'd0, 64'h00001234_00005678, 10, 0);

    // {loen,hien}=11 with an unrelated funct is a no-op
    hien = 1'b1; loen = 1'b1; funct = 6'd32; rs_data = 32'hDEADBEEF;
    #1;
    check("nop_start", {31'd0, start}, 32'd0);
    cycle();
    hien = 1'b0; loen = 1'b0; funct = 6'd0;
    check("nop_busy", {31'd0, busy}, 32'd0);
    check("nop_hi", hi, 32'h00001234);
    check("nop_lo", lo, 32'h00005678);

    // mthi during busy must be ignored: 0x10000 * 0x10000 = 1_00000000
    do_op("mult_mthi", 6'd24, 32'h00010000, 32'h00010000, 64'h00000001_00000000, 5, 2);

    // reset at busy cycle 4 of a div (100/7 would give q=14 r=2)
    hien = 1'b1; loen = 1'b1; funct = 6'd26; rs_data = 32'd100; rt_data = 32'd7;
    exp_q.push_back(64'd0);
    cycle();
    hien = 1'b0; loen = 1'b0; funct = 6'd0;
    cycle();
    cycle();
    cycle();
    check("rstmid_busy_before", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    check("rstmid_busy", {31'd0, busy}, 32'd0);
    check("rstmid_hi", hi, 32'd0);
    check("rstmid_lo", lo, 32'd0);
    for (int i = 0; i < 10; i++) cycle();
    check("rstmid_late_busy", {31'd0, busy}, 32'd0);
    check("rstmid_late_hi", hi, 32'd0);
    check("rstmid_late_lo", lo, 32'd0);

    cycle();
    check("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
